// File: rtl/seq_det_param.sv
// Runtime-programmable serial pattern detector: compares the last PAT_LEN sampled bits to a loadable pattern.
// Optional saturating match counter is built only when SEQDET_MATCH_CNT_EN is defined.
module seq_det_param #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1010,
  parameter int                 CNT_W    = 8,
  localparam int                FILL_W   = $clog2(PAT_LEN + 1)
) (
  input  logic               fsm_clk,
  input  logic               clr,
  input  logic               din,
  input  logic               din_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               seq_det,
  output logic [FILL_W-1:0]  fill,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  generate
    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
      $error("seq_det_param: PAT_LEN must be in 2..16");
    end
  endgenerate

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               det_q, det_d;

  logic [PAT_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               match;

  always_comb begin
    hist_n = {hist_q[PAT_LEN-2:0], din};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match  = din_valid && !pat_load && (fill_n == FILL_FULL) && (hist_n == pat_q);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    det_d  = 1'b0;
    if (pat_load) begin
      // A simultaneous sample is dropped so the new pattern starts from clean history.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      if (match) begin
        det_d = 1'b1;
        if (overlap) begin
          hist_d = hist_n;
          fill_d = FILL_FULL;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = hist_n;
        fill_d = fill_n;
      end
    end
  end

  always_ff @(posedge fsm_clk) begin
    if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PAT_INIT;
      det_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      det_q  <= det_d;
    end
  end

  assign seq_det = det_q;
  assign fill    = fill_q;

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge fsm_clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: a queue-based bit-history model predicts every cycle's outputs.
module tb_seq_det_param;

  localparam int                 PAT_LEN  = 4;
  localparam int                 CNT_W    = 2;
  localparam int                 FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [PAT_LEN-1:0] PAT_INIT = 4'b1010;

  logic               fsm_clk = 1'b0;
  logic               clr = 1'b1;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               overlap = 1'b0;
  logic               pat_load = 1'b0;
  logic [PAT_LEN-1:0] pat_in = '0;
  logic               seq_det;
  logic [FILL_W-1:0]  fill;
  logic [CNT_W-1:0]   match_cnt;

  seq_det_param #(.PAT_LEN(PAT_LEN), .PAT_INIT(PAT_INIT), .CNT_W(CNT_W)) dut (
    .fsm_clk  (fsm_clk),
    .clr      (clr),
    .din      (din),
    .din_valid(din_valid),
    .overlap  (overlap),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .seq_det  (seq_det),
    .fill     (fill),
    .match_cnt(match_cnt)
  );

  always #5 fsm_clk = ~fsm_clk;

  typedef struct {
    logic              det;
    logic [FILL_W-1:0] fill;
    logic [CNT_W-1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  bit m_bits[$];
  int m_pat = int'(PAT_INIT);
  int m_cnt = 0;
  bit m_det = 0;

  function automatic int bits_value();
    int v = 0;
    foreach (m_bits[i]) v = v * 2 + int'(m_bits[i]);
    return v;
  endfunction

  task automatic step(input bit c, input bit ld, input int pin, input bit v, input bit d, input bit ov);
    exp_t e;
    @(negedge fsm_clk);
    clr = c; pat_load = ld; pat_in = PAT_LEN'(pin); din_valid = v; din = d; overlap = ov;
    if (c) begin
      m_bits.delete(); m_pat = int'(PAT_INIT); m_cnt = 0; m_det = 0;
    end else if (ld) begin
      m_bits.delete(); m_pat = pin % (1 << PAT_LEN); m_det = 0;
    end else if (v) begin
      m_bits.push_back(d);
      if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_LEN && bits_value() == m_pat) begin
        m_det = 1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!ov) m_bits.delete();
      end else begin
        m_det = 0;
      end
    end else begin
      m_det = 0;
    end
    e.det  = m_det;
    e.fill = FILL_W'(m_bits.size());
`ifdef SEQDET_MATCH_CNT_EN
    e.cnt  = CNT_W'(m_cnt);
`else
    e.cnt  = '0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic stream(input int bits_val, input int n, input bit ov, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(0, 0, 0, 1, bit'((bits_val >> i) & 1), ov);
      for (int g = 0; g < gap; g++) step(0, 0, 0, 0, bit'($urandom_range(1, 0)), ov);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge fsm_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (seq_det !== e.det) begin
          miscompares++;
          $display("FAIL seq_det at %0t: got %b expected %b", $time, seq_det, e.det);
        end
        if (fill !== e.fill) begin
          miscompares++;
          $display("FAIL fill at %0t: got %0d expected %0d", $time, fill, e.fill);
        end
        if (match_cnt !== e.cnt) begin
          miscompares++;
          $display("FAIL match_cnt at %0t: got %0d expected %0d", $time, match_cnt, e.cnt);
        end
      end
    end
  end

  initial begin : stimulus
    // overlap off: 1,0,1,0,1,0,1
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    stream(7'b1010101, 7, 0, 0);
    // overlap on, same stream
    step(1, 0, 0, 0, 0, 1);
    stream(7'b1010101, 7, 1, 0);
    // gapped strobes with idle-cycle din noise
    step(1, 0, 0, 0, 0, 0);
    stream(4'b1010, 4, 0, 3);
    // pattern load after 3 bits, then 0011
    step(1, 0, 0, 0, 0, 0);
    stream(3'b101, 3, 0, 0);
    step(0, 1, 4'b0011, 0, 0, 0);
    stream(4'b0011, 4, 0, 0);
    // load/sample collision
    stream(2'b00, 2, 0, 0);
    step(0, 1, 4'b0011, 1, 1, 0);
    stream(4'b0011, 4, 1, 1);
    // saturation with pattern 1111, then mid-stream clear
    step(1, 0, 0, 0, 0, 1);
    step(0, 1, 4'b1111, 0, 0, 1);
    stream(10'b1111111111, 10, 1, 0);
    stream(2'b11, 2, 1, 0);
    step(1, 0, 0, 0, 0, 1);
    stream(4'b1010, 4, 1, 0);
    stream(4'b1111, 4, 1, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(199, 0) == 0, $urandom_range(39, 0) == 0, int'($urandom_range(15, 0)),
           $urandom_range(2, 0) != 0, bit'($urandom_range(1, 0)),
           (i / 300) % 2 == 1 ? bit'($urandom_range(1, 0)) : bit'((i / 600) % 2));
    end
    step(0, 0, 0, 0, 0, 0);
    @(posedge fsm_clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
